// File: rtl/multiword_add_seq.sv
// multiword_add_seq: multi-word adder that reuses one 64-bit add stage per beat, LSW first.
// Define MULTIWORD_SUB_EN to add the sub port for A-B.
module multiword_add_seq #(
    parameter int WORDS = 4,
    parameter int CW    = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [64*WORDS-1:0]   op_a,
    input  logic [64*WORDS-1:0]   op_b,
    input  logic                  cin,
`ifdef MULTIWORD_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         beat,
    output logic [64*WORDS-1:0]   sum,
    output logic                  cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [64*WORDS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [CW+5:0] off;
    logic [63:0] bw;
    logic [64:0] s;
`ifdef MULTIWORD_SUB_EN
    logic sub_q, sub_d;
`endif
    always_comb begin
        off = {beat_q, 6'd0};
`ifdef MULTIWORD_SUB_EN
        bw = sub_q ? ~b_q[off +: 64] : b_q[off +: 64];
        sub_d = sub_q;
`else
        bw = b_q[off +: 64];
`endif
        s = {1'b0, a_q[off +: 64]} + {1'b0, bw} + {64'd0, carry_q};
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        carry_d = carry_q;
        cout_d = cout_q;
        beat_d = beat_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d = op_a;
                b_d = op_b;
                sum_d = '0;
                cout_d = 1'b0;
                beat_d = '0;
`ifdef MULTIWORD_SUB_EN
                sub_d = sub;
                carry_d = sub | cin;
`else
                carry_d = cin;
`endif
            end
            RUN: begin
                sum_d[off +: 64] = s[63:0];
                carry_d = s[64];
                beat_d = beat_q + 1'b1;
                if (beat_q == CW'(WORDS - 1)) begin
                    state_d = DONE;
                    cout_d = s[64];
                    beat_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            carry_q <= 1'b0;
            cout_q <= 1'b0;
            beat_q <= '0;
`ifdef MULTIWORD_SUB_EN
            sub_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            carry_q <= carry_d;
            cout_q <= cout_d;
            beat_q <= beat_d;
`ifdef MULTIWORD_SUB_EN
            sub_q <= sub_d;
`endif
        end
    end
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign beat = beat_q;
    assign sum = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: directed and random checks of multiword_add_seq against an arithmetic model.
module tb_multiword_add_seq;
    localparam int WORDS = 4;
    localparam int W = 64 * WORDS;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0, sum;
    logic busy, done, cout;
    logic [1:0] beat;
    int n_cmp = 0, n_err = 0;

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef MULTIWORD_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .beat(beat), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic c, s);
        logic [W:0] bb;
        bb = s ? {1'b0, ~b} : {1'b0, b};
        return {1'b0, a} + bb + (s ? 1 : c);
    endfunction

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, b, input logic c, s);
        logic [W:0] r;
        int n;
        r = model(a, b, c, s);
        op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
        step();
        start = 1'b0; op_a = rnd(); op_b = rnd(); cin = ~c; sub = ~s;
        check({tag, "_busy"}, W'(busy), 1);
        n = 0;
        while (!done && n < 20) begin
            check({tag, "_beat"}, W'(beat), W'(n));
            step();
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(WORDS));
        check({tag, "_sum"}, sum, r[W-1:0]);
        check({tag, "_cout"}, W'(cout), W'(r[W]));
        step();
        check({tag, "_idle"}, W'({busy, done}), 0);
        check({tag, "_hold"}, sum, r[W-1:0]);
    endtask

    initial begin
        int n;
        int pulses;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 2; i++) begin
            start = $urandom; op_a = rnd(); op_b = rnd(); cin = $urandom;
            step();
        end
        check("rst_out", {sum[W-5:0], busy, done, cout, |beat}, 0);
        check("rst_sum", sum, 0);
        start = 1'b0;
        rst = 1'b1;
        step();

        run_op("ripple", {W{1'b1}}, 1, 1'b0, 1'b0);
        check("ripple_zero", sum, 0);
        check("ripple_cout", W'(cout), 1);

        a = 0; a[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_op("carry", a, 1, 1'b1, 1'b0);
        b = 0; b[63:0] = 64'h1; b[127:64] = 64'h1;
        check("carry_words", sum, b);

        op_a = 5; op_b = 7; cin = 1'b0; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        op_a = 1; op_b = 1; start = 1'b1;
        wait_done("busy1", n);
        check("busy_sum", sum, 12);
        check("busy_lat", W'(n), 2);
        step();
        check("busy_done_once", W'({busy, done}), 0);
        step();
        start = 1'b0;
        check("busy_reaccept", W'(busy), 1);
        wait_done("busy2", n);
        check("busy_sum2", sum, 2);
        step();

        op_a = rnd(); op_b = rnd(); start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check("abort_beat", W'(beat), 2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort_out", W'({busy, done, cout, beat}), 0);
        check("abort_sum", sum, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            pulses += int'(done);
            step();
        end
        check("abort_nodone", W'(pulses), 0);
        run_op("fresh", 3, 4, 1'b0, 1'b0);
        check("fresh_sum", sum, 7);

`ifdef MULTIWORD_SUB_EN
        run_op("sub_neg", 0, 1, 1'b0, 1'b1);
        check("sub_neg_sum", sum, {W{1'b1}});
        check("sub_neg_cout", W'(cout), 0);
        run_op("sub_pos", 9, 4, 1'b0, 1'b1);
        check("sub_pos_sum", sum, 5);
        check("sub_pos_cout", W'(cout), 1);
`endif

        for (int i = 0; i < 20; i++) begin
`ifdef MULTIWORD_SUB_EN
            run_op("rand", rnd(), rnd(), 1'($urandom), 1'($urandom));
`else
            run_op("rand", rnd(), rnd(), 1'($urandom), 1'b0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
